uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmit engine with an internal write FIFO, succeeding the fixed-format transmit path inside `uart_ctrl`. Data width, FIFO depth and divisor width are generics. Baud divisor, parity mode and stop-bit count are run-time inputs. It sits between a bus-side writer, which pushes words with `WRITE`, and the serial `TX` pin.

## Interface
- `DATA_BITS`, default 8: frame data width; legal range 5..9.
- `DEPTH`, default 16: FIFO depth in words; power of two, at least 2.
- `DIV_W`, default 16: width of the baud divisor input.
- `CLK` in, 1 bit: single clock; all logic is on the rising edge.
- `RST_N` in, 1 bit: reset, asynchronous, active-low.
- `TXEN` in, 1 bit: permits the start of new frames.
- `DIV` in, `DIV_W` bits: bit period is `DIV`+1 clock cycles.
- `PARITY` in, 2 bits: 00 none, 01 even, 10 odd, 11 none.
- `STOP2` in, 1 bit: 1 selects two stop bits, 0 selects one.
- `WRITE` in, 1 bit: push request, qualified per cycle.
- `WRDATA` in, `DATA_BITS` bits: word to push.
- `CLR_OVF` in, 1 bit: clears `OVERFLOW`.
- `TX` out, 1 bit: serial line; idles high.
- `ISFULL` out, 1 bit: FIFO holds `DEPTH` words.
- `ISEMPTY` out, 1 bit: FIFO holds 0 words.
- `BUSY` out, 1 bit: a frame is in progress (state is not IDLE).
- `OVERFLOW` out, 1 bit: sticky flag; set when a write arrives while full.

## Operation
- Reset values: `TX`=1, `ISFULL`=0, `ISEMPTY`=1, `BUSY`=0, `OVERFLOW`=0. Reset also sets state IDLE, clears the FIFO pointers and clears the baud counter. Reset mid-frame aborts the frame; `TX` returns high asynchronously.
- FIFO push: `WRITE` with `ISFULL`=0 stores `WRDATA`. `WRITE` with `ISFULL`=1 drops the word and sets `OVERFLOW`.
- Push and pop in the same cycle on a full FIFO: the pop frees a slot first, so the push is accepted.
- `CLR_OVF` clears `OVERFLOW`. If `CLR_OVF` and an overflowing write occur in the same cycle, set wins.
- State machine states: IDLE, START, DATA, PAR, STOP.
  - IDLE to START when `TXEN`=1 and `ISEMPTY`=0. The FIFO pops in this cycle.
  - At the same transition the word, `DIV`, `PARITY` and `STOP2` are latched. Config changes during a frame do not affect that frame.
  - START drives `TX`=0 for one bit period.
  - DATA shifts out `DATA_BITS` bits, LSB first.
  - PAR runs only when parity is enabled. Even mode sends the XOR of the data bits; odd mode sends its inverse.
  - STOP drives `TX`=1 for 1 or 2 bit periods.
  - At the end of STOP the next state is START if `TXEN`=1 and the FIFO is non-empty, otherwise IDLE. Frames are sent back to back with no idle gap.
- `TXEN` dropping mid-frame: the current frame completes, then the engine stays in IDLE.
- Baud counter: loads the latched `DIV` at each bit boundary, counts down to 0, and advances the bit at 0. `DIV`=0 gives 1 cycle per bit.
- Bit counter is 4 bits wide. Wrap is impossible because `DATA_BITS` is at most 9.

## Timing
- `WRITE` sampled at edge n: `ISEMPTY` falls after edge n. If the engine is idle with `TXEN`=1, the pop occurs at edge n+1 and `TX` falls after edge n+1. Write-to-start-bit latency is 2 cycles.
- Every bit lasts exactly `DIV`+1 cycles.
- Frame length in bits is 1 + `DATA_BITS` + P + S, where P is 0 or 1 for parity and S is 1 or 2 for stop bits.
- `BUSY` is high from the cycle after the pop through the last stop-bit cycle.
- `ISFULL` and `ISEMPTY` are registered and update on the edge following the push or pop.

## Structure
- Package `uart_pkg` holds:
  - the state enum `tx_state_t` (IDLE, START, DATA, PAR, STOP);
  - the parity enum `parity_t` (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2);
  - the constant `MAX_DATA_BITS`=9.
- Sub-module `sync_fifo`, parametrised in WIDTH and DEPTH, has full/empty outputs and first-word-fall-through read data. It is instantiated once. The remaining logic is the state machine, baud counter, shift register and parity bit.

## Test plan
- 8N1, `DIV`=3, write 0xA5 → `TX`, 4 cycles per bit, reads 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1. Frame is 40 cycles and `TX` falls 2 cycles after `WRITE`.
- 8E2 with 0x07 → parity bit 1, two stop bits, 12 bits total. 8O1 with 0x07 → parity bit 0.
- `DEPTH`=4 with `TXEN`=0, 5 writes → `ISFULL` after the 4th write and `OVERFLOW`=1 after the 5th. Raise `TXEN` → exactly 4 frames back to back with no idle cycles, then `ISEMPTY`=1 and `BUSY`=0.
- `DATA_BITS`=5, write 0x1F (upper bits ignored) → 7-bit frame. Change `DIV` mid-frame → the current frame keeps the old period and the next frame uses the new one.
- `TXEN` dropped during the DATA state with 2 words queued → the current frame completes and `TX` stays high. `RST_N` asserted mid-frame → `TX`=1 immediately and all flags return to reset values.
- Write to a full FIFO in the same cycle as a pop → word accepted and `OVERFLOW` stays 0. `CLR_OVF` and an overflowing write in the same cycle → `OVERFLOW`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmit path.
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and first-word-fall-through read data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic [AW:0]      count_nxt_s;

    // A pop frees its slot before a same-cycle push is judged against full.
    always_comb begin
        do_pop_s    = pop && !empty_r;
        do_push_s   = push && (!full_r || do_pop_s);
        count_nxt_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (do_pop_s && !do_push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_MAX);
            empty_r <= (count_nxt_s == {(AW + 1){1'b0}});
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/uart_tx_param.sv
// UART transmit engine: write FIFO feeding a framer with run-time baud, parity and stop-bit selection.
module uart_tx_param #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 txen,
    input  logic [DIV_W-1:0]     div,
    input  logic [1:0]           parity,
    input  logic                 stop2,
    input  logic                 write,
    input  logic [DATA_BITS-1:0] wrdata,
    input  logic                 clr_ovf,
    output logic                 tx,
    output logic                 isfull,
    output logic                 isempty,
    output logic                 busy,
    output logic                 overflow
);
    import uart_pkg::*;

    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] BAUD_ONE = DIV_W'(1);

    logic [DATA_BITS-1:0] fifo_rdata_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 bit_done_s;
    logic                 frame_end_s;
    logic                 start_s;
    logic                 ovf_set_s;

    tx_state_t            state_r;
    logic [DIV_W-1:0]     baud_r;
    logic [DIV_W-1:0]     div_r;
    logic [3:0]           bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_en_r;
    logic                 par_bit_r;
    logic                 stop2_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 ovf_r;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (write),
        .pop   (start_s),
        .wdata (wrdata),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // A new frame starts from IDLE or straight out of the final stop bit.
    always_comb begin
        bit_done_s  = (baud_r == {DIV_W{1'b0}});
        frame_end_s = (state_r == STOP) && bit_done_s && (!stop2_r || (bit_cnt_r == 4'd1));
        start_s     = txen && !fifo_empty_s && ((state_r == IDLE) || frame_end_s);
        ovf_set_s   = write && fifo_full_s && !start_s;
    end

    // Framer state machine with baud counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            baud_r    <= {DIV_W{1'b0}};
            div_r     <= {DIV_W{1'b0}};
            bit_cnt_r <= 4'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            stop2_r   <= 1'b0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else if (start_s) begin
            state_r   <= START;
            baud_r    <= div;
            div_r     <= div;
            bit_cnt_r <= 4'd0;
            shift_r   <= fifo_rdata_s;
            par_en_r  <= (parity == PAR_EVEN) || (parity == PAR_ODD);
            par_bit_r <= parity_bit(MAX_DATA_BITS'(fifo_rdata_s), parity == PAR_ODD);
            stop2_r   <= stop2;
            tx_r      <= 1'b0;
            busy_r    <= 1'b1;
        end else if (!bit_done_s) begin
            baud_r <= baud_r - BAUD_ONE;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                end
                START: begin
                    state_r   <= DATA;
                    baud_r    <= div_r;
                    bit_cnt_r <= 4'd0;
                    tx_r      <= shift_r[0];
                    shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                end
                DATA: begin
                    baud_r <= div_r;
                    if (bit_cnt_r != LAST_BIT) begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        tx_r      <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                    end else if (par_en_r) begin
                        state_r <= PAR;
                        tx_r    <= par_bit_r;
                    end else begin
                        state_r   <= STOP;
                        bit_cnt_r <= 4'd0;
                        tx_r      <= 1'b1;
                    end
                end
                PAR: begin
                    state_r   <= STOP;
                    baud_r    <= div_r;
                    bit_cnt_r <= 4'd0;
                    tx_r      <= 1'b1;
                end
                STOP: begin
                    if (frame_end_s) begin
                        state_r <= IDLE;
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        bit_cnt_r <= 4'd1;
                        baud_r    <= div_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow; a dropped write outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (clr_ovf) begin
            ovf_r <= 1'b0;
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign overflow = ovf_r;
    assign isfull   = fifo_full_s;
    assign isempty  = fifo_empty_s;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: a waveform model built from frame rules, table vectors and corner sequences.
module tb_uart_tx_param;

    logic        clk = 1'b0;
    logic        rst_n, txen, stop2, clr_ovf;
    logic [15:0] div;
    logic [1:0]  parity;
    logic        a_write, b_write;
    logic [7:0]  a_wrdata;
    logic [4:0]  b_wrdata;
    logic        a_tx, a_isfull, a_isempty, a_busy, a_overflow;
    logic        b_tx, b_isfull, b_isempty, b_busy, b_overflow;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];
    logic cap_q[$];

    typedef struct {
        logic [7:0] data;
        logic [1:0] pm;
        logic       s2;
        int         dv;
        int         exp_bits;
        logic       exp_par;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .DEPTH(4), .DIV_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .txen(txen), .div(div), .parity(parity), .stop2(stop2),
        .write(a_write), .wrdata(a_wrdata), .clr_ovf(clr_ovf),
        .tx(a_tx), .isfull(a_isfull), .isempty(a_isempty), .busy(a_busy), .overflow(a_overflow)
    );

    uart_tx_param #(.DATA_BITS(5), .DEPTH(4), .DIV_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .txen(txen), .div(div), .parity(parity), .stop2(stop2),
        .write(b_write), .wrdata(b_wrdata), .clr_ovf(clr_ovf),
        .tx(b_tx), .isfull(b_isfull), .isempty(b_isempty), .busy(b_busy), .overflow(b_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Expected line level per clock for one frame, from the framing rules.
    task automatic model_frame(input logic [8:0] w, input int nbits, input logic [1:0] pm,
                               input logic s2, input int dv);
        logic       bits[$];
        logic [8:0] m;
        int         ones;
        m = w;
        for (int i = nbits; i < 9; i++) m[i] = 1'b0;
        ones = $countones(m);
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(w[i]);
        if (pm == 2'd1) bits.push_back(ones[0]);
        if (pm == 2'd2) bits.push_back(~ones[0]);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) repeat (dv + 1) exp_q.push_back(bits[i]);
    endtask

    task automatic model_idle(input int n);
        repeat (n) exp_q.push_back(1'b1);
    endtask

    task automatic capture(input int n, input bit on_b, input int chg_at, input logic [15:0] new_div,
                           input bit scr, input int drop_at);
        for (int i = 0; i < n; i++) begin
            if (i == chg_at) begin
                div = new_div;
                if (scr) begin
                    parity = 2'($urandom);
                    stop2  = 1'($urandom);
                end
            end
            if (i == drop_at) txen = 1'b0;
            cap_q.push_back(on_b ? b_tx : a_tx);
            tick();
        end
    endtask

    task automatic cmp_wave(input string name);
        int bad;
        bad = -1;
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            bad = 0;
        end else begin
            foreach (cap_q[i]) if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
        end
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: first bad cycle %0d got %b expected %b (len %0d vs %0d)", name, bad,
                     cap_q[bad], exp_q[bad], cap_q.size(), exp_q.size());
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    // One frame on instance A from idle: write, check latency, capture, leave waveform for compare.
    task automatic do_frame(input logic [7:0] data, input logic [1:0] pm, input logic s2,
                            input int dv, input int nbits_frame);
        int total;
        total    = nbits_frame * (dv + 1);
        div      = 16'(dv);
        parity   = pm;
        stop2    = s2;
        a_wrdata = data;
        a_write  = 1'b1;
        tick();
        chk("isempty_after_write", a_isempty, 1'b0);
        chk("tx_high_one_cycle_after_write", a_tx, 1'b1);
        a_write = 1'b0;
        tick();
        chk("busy_at_start_bit", a_busy, 1'b1);
        capture(total, 1'b0, total / 2, 16'($urandom_range(0, 7)), 1'b1, -1);
        model_frame({1'b0, data}, 8, pm, s2, dv);
    endtask

    initial begin
        logic [7:0] fw[5];
        int         nb;
        int         pidx;

        vecs[0] = '{data: 8'hA5, pm: 2'd0, s2: 1'b0, dv: 3, exp_bits: 10, exp_par: 1'b0};
        vecs[1] = '{data: 8'h07, pm: 2'd1, s2: 1'b1, dv: 1, exp_bits: 12, exp_par: 1'b1};
        vecs[2] = '{data: 8'h07, pm: 2'd2, s2: 1'b0, dv: 0, exp_bits: 11, exp_par: 1'b0};
        vecs[3] = '{data: 8'h3C, pm: 2'd3, s2: 1'b1, dv: 2, exp_bits: 11, exp_par: 1'b0};
        vecs[4] = '{data: 8'hFF, pm: 2'd2, s2: 1'b0, dv: 4, exp_bits: 11, exp_par: 1'b1};

        rst_n = 1'b0; txen = 1'b0; stop2 = 1'b0; clr_ovf = 1'b0; div = 16'd0; parity = 2'd0;
        a_write = 1'b0; b_write = 1'b0; a_wrdata = 8'd0; b_wrdata = 5'd0;
        tick();
        tick();
        chk("reset_tx", a_tx, 1'b1);
        chk("reset_isfull", a_isfull, 1'b0);
        chk("reset_isempty", a_isempty, 1'b1);
        chk("reset_busy", a_busy, 1'b0);
        chk("reset_overflow", a_overflow, 1'b0);
        chk("reset_tx_b", b_tx, 1'b1);
        rst_n = 1'b1;
        txen  = 1'b1;
        tick();

        // Table vectors.
        for (int v = 0; v < 5; v++) begin
            do_frame(vecs[v].data, vecs[v].pm, vecs[v].s2, vecs[v].dv, vecs[v].exp_bits);
            if (vecs[v].pm == 2'd1 || vecs[v].pm == 2'd2) begin
                pidx = 9 * (vecs[v].dv + 1);
                chk($sformatf("parity_bit_vec%0d", v), cap_q[pidx], vecs[v].exp_par);
            end
            cmp_wave($sformatf("frame_vec%0d", v));
            chk("busy_low_after_frame", a_busy, 1'b0);
            chk("tx_idle_after_frame", a_tx, 1'b1);
        end

        // Randomized frames against the model.
        for (int r = 0; r < 8; r++) begin
            logic [1:0] pm;
            logic       s2;
            int         dv;
            pm = 2'($urandom);
            s2 = 1'($urandom);
            dv = $urandom_range(0, 5);
            nb = 1 + 8 + ((pm == 2'd1 || pm == 2'd2) ? 1 : 0) + (s2 ? 2 : 1);
            do_frame(8'($urandom), pm, s2, dv, nb);
            cmp_wave($sformatf("random_frame%0d", r));
            chk("random_busy_low", a_busy, 1'b0);
        end

        // Fill to full, overflow, clear priority, then drain back to back.
        txen = 1'b0; div = 16'd1; parity = 2'd0; stop2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fw[i]    = 8'($urandom);
            a_write  = 1'b1;
            a_wrdata = fw[i];
            tick();
            if (i == 2) chk("not_full_after_3", a_isfull, 1'b0);
            if (i == 3) chk("full_after_4", a_isfull, 1'b1);
            if (i == 4) chk("overflow_after_5", a_overflow, 1'b1);
        end
        clr_ovf = 1'b1;
        tick();
        chk("overflow_set_wins_over_clear", a_overflow, 1'b1);
        a_write = 1'b0;
        tick();
        chk("overflow_cleared", a_overflow, 1'b0);
        clr_ovf = 1'b0;
        txen    = 1'b1;
        tick();
        chk("not_full_after_pop", a_isfull, 1'b0);
        capture(80, 1'b0, -1, 16'd0, 1'b0, -1);
        for (int i = 0; i < 4; i++) model_frame({1'b0, fw[i]}, 8, 2'd0, 1'b0, 1);
        cmp_wave("four_frames_back_to_back");
        chk("drain_isempty", a_isempty, 1'b1);
        chk("drain_busy_low", a_busy, 1'b0);

        // Push into a full FIFO on the same edge as a pop.
        txen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fw[i]    = 8'($urandom);
            a_write  = 1'b1;
            a_wrdata = fw[i];
            tick();
        end
        fw[4]    = 8'($urandom);
        a_wrdata = fw[4];
        txen     = 1'b1;
        tick();
        a_write = 1'b0;
        chk("push_pop_full_no_overflow", a_overflow, 1'b0);
        chk("push_pop_full_stays_full", a_isfull, 1'b1);
        capture(100, 1'b0, -1, 16'd0, 1'b0, -1);
        for (int i = 0; i < 5; i++) model_frame({1'b0, fw[i]}, 8, 2'd0, 1'b0, 1);
        cmp_wave("five_frames_after_push_pop");
        chk("push_pop_drain_empty", a_isempty, 1'b1);

        // TXEN dropped during DATA with two words queued.
        txen     = 1'b0;
        a_write  = 1'b1;
        a_wrdata = 8'h5A;
        tick();
        a_wrdata = 8'h00;
        tick();
        a_write = 1'b0;
        div = 16'd2; parity = 2'd1; stop2 = 1'b0;
        txen = 1'b1;
        tick();
        capture(45, 1'b0, -1, 16'd0, 1'b0, 6);
        model_frame(9'h05A, 8, 2'd1, 1'b0, 2);
        model_idle(12);
        cmp_wave("txen_drop_completes_frame");
        chk("txen_drop_busy_low", a_busy, 1'b0);
        chk("txen_drop_word_held", a_isempty, 1'b0);

        // Reset in the middle of a frame.
        txen = 1'b1;
        tick();
        repeat (5) tick();
        chk("tx_low_before_reset", a_tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", a_tx, 1'b1);
        chk("async_reset_busy", a_busy, 1'b0);
        chk("async_reset_isempty", a_isempty, 1'b1);
        chk("async_reset_isfull", a_isfull, 1'b0);
        chk("async_reset_overflow", a_overflow, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("tx_idle_after_reset", a_tx, 1'b1);

        // Five-bit instance: DIV change mid-frame applies only to the next frame.
        txen     = 1'b0;
        b_write  = 1'b1;
        b_wrdata = 5'h1F;
        tick();
        b_wrdata = 5'h0A;
        tick();
        b_write = 1'b0;
        div = 16'd2; parity = 2'd0; stop2 = 1'b0;
        txen = 1'b1;
        tick();
        capture(28, 1'b1, 4, 16'd0, 1'b0, -1);
        model_frame(9'h01F, 5, 2'd0, 1'b0, 2);
        model_frame(9'h00A, 5, 2'd0, 1'b0, 0);
        cmp_wave("five_bit_div_change");
        chk("five_bit_busy_low", b_busy, 1'b0);
        chk("five_bit_empty", b_isempty, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
